dict_value_frame_sequencer: RTL and testbench

- Controller that feeds the dictionary-value compressor one frame at a time and returns the compressed result.
- Accepts a parallel frame of NUM_CHUNKS*CHUNK_SIZE bits on a valid/ready handshake.
- Serialises the frame MSB-first onto the compressor's 1-bit data_in/data_valid port, waits for compression_done, then captures compressed_output and presents it on a valid/ready result handshake.
- Sits between the frame source (bus/DMA side) and the compressor datapath. It owns all sequencing; the compressor only ever sees clean bursts.

---
 rtl/dict_value_frame_sequencer_if.sv | 23 ++
 rtl/dict_value_frame_sequencer.sv | 136 +++++++++++++
 tb/tb_dict_value_frame_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dict_value_frame_sequencer_if.sv
// rtl/dict_value_frame_sequencer_if.sv - frame-in and result-out handshake bundle for the sequencer
interface dict_value_frame_sequencer_if #(
    parameter int STREAM_LEN = 128,
    parameter int OUT_W      = 64
);
    logic [STREAM_LEN-1:0] frame_in;
    logic                  frame_valid;
    logic                  frame_ready;
    logic [OUT_W-1:0]      result;
    logic                  result_valid;
    logic                  result_ready;

    // master: frame source plus result consumer; slave: the sequencer
    modport master (
        output frame_in, frame_valid, result_ready,
        input  frame_ready, result, result_valid
    );

    modport slave (
        input  frame_in, frame_valid, result_ready,
        output frame_ready, result, result_valid
    );
endinterface

// File: rtl/dict_value_frame_sequencer.sv
// rtl/dict_value_frame_sequencer.sv - serialises frames into the dictionary compressor and returns its result
// Optional WAIT-state watchdog enabled by defining DICT_SEQ_TIMEOUT_EN.
module dict_value_frame_sequencer #(
    parameter int  CHUNK_SIZE     = 8,
    parameter int  CODEBOOK_SIZE  = 16,
    parameter int  NUM_CHUNKS     = 16,
    parameter int  TIMEOUT_CYCLES = 64,
    localparam int INDEX_BITS     = $clog2(CODEBOOK_SIZE),
    localparam int STREAM_LEN     = NUM_CHUNKS * CHUNK_SIZE,
    localparam int OUT_W          = NUM_CHUNKS * INDEX_BITS
) (
    input  logic                                clk,
    input  logic                                rst_n,
    dict_value_frame_sequencer_if.slave         bus,
    output logic                                comp_start,
    output logic                                comp_data_in,
    output logic                                comp_data_valid,
    input  logic [OUT_W-1:0]                    comp_output,
    input  logic                                comp_done,
    output logic                                busy,
    output logic                                timeout_err,
    output logic [15:0]                         frame_count
);
    localparam int CNT_W = $clog2(STREAM_LEN);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(STREAM_LEN - 1);

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_SHIFT,
        S_WAIT,
        S_OUT
    } state_t;

    state_t                state;
    logic [STREAM_LEN-1:0] shreg;
    logic [CNT_W-1:0]      bit_cnt;

`ifdef DICT_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wdog;
`else
    assign timeout_err = 1'b0;
`endif

    // All handshake and compressor-side outputs are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            shreg            <= '0;
            bit_cnt          <= '0;
            bus.frame_ready  <= 1'b1;
            bus.result       <= '0;
            bus.result_valid <= 1'b0;
            comp_start       <= 1'b0;
            comp_data_in     <= 1'b0;
            comp_data_valid  <= 1'b0;
            busy             <= 1'b0;
            frame_count      <= '0;
`ifdef DICT_SEQ_TIMEOUT_EN
            wdog             <= '0;
            timeout_err      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.frame_valid) begin
                        shreg           <= bus.frame_in;
                        bit_cnt         <= '0;
                        comp_start      <= 1'b1;
                        bus.frame_ready <= 1'b0;
                        busy            <= 1'b1;
                        state           <= S_START;
                    end
                end
                S_START: begin
                    // First bit leaves here so data_valid is gap-free for the whole frame.
                    comp_start      <= 1'b0;
                    comp_data_valid <= 1'b1;
                    comp_data_in    <= shreg[STREAM_LEN-1];
                    shreg           <= {shreg[STREAM_LEN-2:0], 1'b0};
                    state           <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (bit_cnt == LAST_BIT) begin
                        comp_data_valid <= 1'b0;
                        comp_data_in    <= 1'b0;
                        state           <= S_WAIT;
`ifdef DICT_SEQ_TIMEOUT_EN
                        wdog            <= '0;
`endif
                    end else begin
                        comp_data_in <= shreg[STREAM_LEN-1];
                        shreg        <= {shreg[STREAM_LEN-2:0], 1'b0};
                        bit_cnt      <= bit_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (comp_done) begin
                        bus.result       <= comp_output;
                        bus.result_valid <= 1'b1;
                        state            <= S_OUT;
                    end
`ifdef DICT_SEQ_TIMEOUT_EN
                    else if (wdog == WD_LAST) begin
                        bus.result       <= '0;
                        bus.result_valid <= 1'b1;
                        timeout_err      <= 1'b1;
                        state            <= S_OUT;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
`endif
                end
                S_OUT: begin
                    if (bus.result_ready) begin
                        bus.result_valid <= 1'b0;
                        bus.frame_ready  <= 1'b1;
                        busy             <= 1'b0;
                        frame_count      <= frame_count + 16'd1;
                        state            <= S_IDLE;
`ifdef DICT_SEQ_TIMEOUT_EN
                        timeout_err      <= 1'b0;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dict_value_frame_sequencer.sv
// tb/tb_dict_value_frame_sequencer.sv - directed vector bench with a behavioural compressor model
module tb_dict_value_frame_sequencer;
    localparam int STREAM_LEN = 128;
    localparam int OUT_W      = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dict_value_frame_sequencer_if #(.STREAM_LEN(STREAM_LEN), .OUT_W(OUT_W)) bus ();

    logic             comp_start, comp_data_in, comp_data_valid, busy, timeout_err;
    logic             comp_done   = 1'b0;
    logic [OUT_W-1:0] comp_output = '0;
    logic [15:0]      frame_count;

    dict_value_frame_sequencer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .comp_start      (comp_start),
        .comp_data_in    (comp_data_in),
        .comp_data_valid (comp_data_valid),
        .comp_output     (comp_output),
        .comp_done       (comp_done),
        .busy            (busy),
        .timeout_err     (timeout_err),
        .frame_count     (frame_count)
    );

    typedef struct {
        logic [STREAM_LEN-1:0] frame;
        logic [OUT_W-1:0]      co;
        int                    dly;
        int                    hold;
        bit                    stale;
        logic [OUT_W-1:0]      exp_res;
        logic                  exp_to;
        int                    exp_lat;
        logic [15:0]           exp_cnt;
    } vec_t;

    vec_t vecs[4];
    vec_t wd_vec;

    int passed = 0;
    int total  = 0;

    logic [STREAM_LEN-1:0] src_frame = '0;
    logic                  src_valid = 1'b0;
    logic                  src_ready = 1'b0;
    bit                    b2b_mode  = 1'b0;
    int                    b2b_idx   = 0;
    logic [STREAM_LEN-1:0] b2b_frames[4];
    logic [OUT_W-1:0]      b2b_out[4];
    logic [OUT_W-1:0]      b2b_res[4];
    int                    nres      = 0;

    assign bus.frame_in     = (b2b_mode && b2b_idx < 4) ? b2b_frames[b2b_idx] : src_frame;
    assign bus.frame_valid  = b2b_mode ? (b2b_idx < 4) : src_valid;
    assign bus.result_ready = b2b_mode ? 1'b1 : src_ready;

    int               model_delay = 0;
    logic [OUT_W-1:0] model_out   = '0;
    bit               model_stale = 1'b0;
    logic [OUT_W-1:0] cur_out     = '0;
    bit               armed = 0, prev_valid = 0, prev_rv = 0, fell = 0;
    int               wait_cnt = 0, cyc = 0, entry_cyc = 0, rise_cyc = 0;
    int               start_cnt = 0, mon_bits = 0, gap = 0, both_cnt = 0, rdy_err = 0;
    logic [STREAM_LEN-1:0] cap = '0;

    // Compressor model and serial monitor, all sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            armed = 0; comp_done = 1'b0; prev_valid = 0; prev_rv = 0; b2b_idx = 0; nres = 0;
        end else begin
            if (comp_start) begin
                start_cnt++; mon_bits = 0; cap = '0; gap = 0; fell = 0; armed = 0;
                if (b2b_mode) begin
                    cur_out = b2b_out[b2b_idx];
                    b2b_idx++;
                end
                comp_done = model_stale;
                if (model_stale) comp_output = 64'hBADB_ADBA_DBAD_BADB;
            end
            if (comp_data_valid) begin
                if (fell) gap++;
                cap = {cap[STREAM_LEN-2:0], comp_data_in};
                mon_bits++;
            end else if (mon_bits > 0) begin
                fell = 1;
            end
            if (prev_valid && !comp_data_valid) begin
                armed = 1; wait_cnt = 0; entry_cyc = cyc;
            end
            if (armed) begin
                if (model_delay >= 0 && wait_cnt == model_delay) begin
                    comp_done   = 1'b1;
                    comp_output = b2b_mode ? cur_out : model_out;
                    armed       = 0;
                end else begin
                    wait_cnt++;
                end
            end
            prev_valid = comp_data_valid;
            if (bus.result_valid && !prev_rv) rise_cyc = cyc;
            prev_rv = bus.result_valid;
            if (bus.frame_ready && bus.result_valid) both_cnt++;
            if (bus.frame_ready == busy) rdy_err++;
            if (b2b_mode && bus.result_valid && nres < 4) begin
                b2b_res[nres] = bus.result;
                nres++;
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        int n;
        int s0;
        int bad;
        model_delay = v.dly;
        model_out   = v.co;
        model_stale = v.stale;
        @(negedge clk);
        s0 = start_cnt;
        src_frame = v.frame; src_valid = 1'b1; src_ready = 1'b0;
        n = 0;
        while (!bus.frame_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        src_valid = 1'b0;
        n = 0;
        while (!bus.result_valid && n < 400) begin @(negedge clk); n++; end
        check({tag, " result_valid"}, 128'(bus.result_valid), 128'd1);
        check({tag, " start_pulses"}, 128'(start_cnt - s0), 128'd1);
        check({tag, " bit_count"}, 128'(mon_bits), 128'(STREAM_LEN));
        check({tag, " valid_gaps"}, 128'(gap), 128'd0);
        check({tag, " serial_bits"}, cap, v.frame);
        check({tag, " result"}, 128'(bus.result), 128'(v.exp_res));
        check({tag, " timeout_err"}, 128'(timeout_err), 128'(v.exp_to));
        bad = 0;
        repeat (v.hold) begin
            @(negedge clk);
            if (bus.result_valid !== 1'b1 || bus.result !== v.exp_res ||
                timeout_err !== v.exp_to || frame_count !== v.exp_cnt - 16'd1) bad++;
        end
        check({tag, " hold_stable"}, 128'(bad), 128'd0);
        src_ready = 1'b1;
        @(negedge clk);
        src_ready = 1'b0;
        check({tag, " valid_drop"}, 128'(bus.result_valid), 128'd0);
        check({tag, " ready_back"}, 128'(bus.frame_ready), 128'd1);
        check({tag, " busy_clear"}, 128'(busy), 128'd0);
        check({tag, " frame_count"}, 128'(frame_count), 128'(v.exp_cnt));
        check({tag, " timeout_clear"}, 128'(timeout_err), 128'd0);
        check({tag, " done_latency"}, 128'(rise_cyc - entry_cyc), 128'(v.exp_lat));
    endtask

    initial begin
        int n;
        vecs[0] = '{frame: 128'h8000_0000_0000_0000_0000_0000_0000_0001, co: 64'h0123_4567_89AB_CDEF,
                    dly: 3, hold: 5, stale: 0, exp_res: 64'h0123_4567_89AB_CDEF, exp_to: 1'b0,
                    exp_lat: 4, exp_cnt: 16'd1};
        vecs[1] = '{frame: 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5, co: 64'hFEDC_BA98_7654_3210,
                    dly: 0, hold: 0, stale: 1, exp_res: 64'hFEDC_BA98_7654_3210, exp_to: 1'b0,
                    exp_lat: 1, exp_cnt: 16'd2};
        vecs[2] = '{frame: 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, co: 64'h0000_0000_0000_0001,
                    dly: 10, hold: 2, stale: 0, exp_res: 64'h0000_0000_0000_0001, exp_to: 1'b0,
                    exp_lat: 11, exp_cnt: 16'd3};
        vecs[3] = '{frame: 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, co: 64'hFFFF_FFFF_FFFF_FFFF,
                    dly: 1, hold: 0, stale: 0, exp_res: 64'hFFFF_FFFF_FFFF_FFFF, exp_to: 1'b0,
                    exp_lat: 2, exp_cnt: 16'd4};
`ifdef DICT_SEQ_TIMEOUT_EN
        wd_vec  = '{frame: 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F, co: 64'hDEAD_BEEF_DEAD_BEEF,
                    dly: -1, hold: 3, stale: 0, exp_res: 64'h0, exp_to: 1'b1,
                    exp_lat: 64, exp_cnt: 16'd5};
`else
        wd_vec  = '{frame: 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F, co: 64'hDEAD_BEEF_DEAD_BEEF,
                    dly: 100, hold: 3, stale: 0, exp_res: 64'hDEAD_BEEF_DEAD_BEEF, exp_to: 1'b0,
                    exp_lat: 101, exp_cnt: 16'd5};
`endif
        b2b_frames[0] = 128'h1111_1111_1111_1111_1111_1111_1111_1111;
        b2b_frames[1] = 128'h2222_2222_2222_2222_2222_2222_2222_2222;
        b2b_frames[2] = 128'h3333_3333_3333_3333_3333_3333_3333_3333;
        b2b_frames[3] = 128'h4444_4444_4444_4444_4444_4444_4444_4444;
        b2b_out[0] = 64'hAAAA_0000_0000_0001;
        b2b_out[1] = 64'hBBBB_0000_0000_0002;
        b2b_out[2] = 64'hCCCC_0000_0000_0003;
        b2b_out[3] = 64'hDDDD_0000_0000_0004;

        repeat (3) @(negedge clk);
        check("rst frame_ready", 128'(bus.frame_ready), 128'd1);
        check("rst result_valid", 128'(bus.result_valid), 128'd0);
        check("rst busy", 128'(busy), 128'd0);
        check("rst comp_start", 128'(comp_start), 128'd0);
        check("rst data_valid", 128'(comp_data_valid), 128'd0);
        check("rst frame_count", 128'(frame_count), 128'd0);
        check("rst result", 128'(bus.result), 128'd0);
        check("rst timeout_err", 128'(timeout_err), 128'd0);
        rst_n = 1'b1;

        // Reset in the middle of SHIFT must abandon the frame.
        model_delay = 3; model_stale = 0; model_out = 64'h1111_2222_3333_4444;
        @(negedge clk);
        src_frame = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF; src_valid = 1'b1;
        @(negedge clk);
        src_valid = 1'b0;
        n = 0;
        while (mon_bits < 40 && n < 200) begin @(negedge clk); n++; end
        check("midrst reached_shift", 128'(comp_data_valid), 128'd1);
        rst_n = 1'b0;
        #1;
        check("midrst data_valid", 128'(comp_data_valid), 128'd0);
        check("midrst frame_ready", 128'(bus.frame_ready), 128'd1);
        check("midrst busy", 128'(busy), 128'd0);
        check("midrst result_valid", 128'(bus.result_valid), 128'd0);
        check("midrst frame_count", 128'(frame_count), 128'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) run_frame(vecs[i], $sformatf("vec%0d", i));
        run_frame(wd_vec, "wdog");

        // Back-to-back frames with the source and sink always ready.
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_delay = 2; model_stale = 0;
        @(negedge clk);
        b2b_mode = 1'b1;
        n = 0;
        while (nres < 4 && n < 3000) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        check("b2b result_count", 128'(nres), 128'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("b2b result%0d", i), 128'(b2b_res[i]), 128'(b2b_out[i]));
        check("b2b frame_count", 128'(frame_count), 128'd4);
        check("b2b idle", 128'(busy), 128'd0);
        b2b_mode = 1'b0;

        check("ready_and_valid_overlap", 128'(both_cnt), 128'd0);
        check("ready_outside_idle", 128'(rdy_err), 128'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
